adder_operand_sequencer: RTL and testbench

Sits directly upstream of the 4-bit ripple-carry adder on the board top level and also captures the adder's output. An operator enters operand A, then operand B and carry-in, from the switches. Each entry is confirmed by one debounced push-button press. The block drives the adder with the stored operands, waits a settle interval, then latches the 5-bit result for LEDR/HEX display.

---
 rtl/adder_operand_sequencer.sv | 161 ++++++++++++++++
 tb/tb_adder_operand_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_sequencer.sv
// Operand entry sequencer for the board's 4-bit ripple-carry adder.
// One debounced button press confirms each entry, and the adder's output is latched after a settle delay.
module adder_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [3:0] sw_data,
  input  logic       sw_cin,
  input  logic       load_n,
  input  logic [3:0] sum_in,
  input  logic       cout_in,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       cin,
  output logic [4:0] result,
  output logic       result_valid,
  output logic [1:0] stage
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_SUM  = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  logic          sync1_q, syncN_q;
  logic          debN_q, debN_d, debPrev_q, press_q;
  logic [DW-1:0] debCnt_q, debCnt_d;

  state_t        state_q, state_d;
  logic [3:0]    opA_q, opA_d, opB_q, opB_d;
  logic          cin_q, cin_d, valid_q, valid_d;
  logic [4:0]    result_q, result_d;
  logic [SW-1:0] settleCnt_q, settleCnt_d;

  // load_n is asynchronous to CLOCK_50, so it goes through two flops first.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      syncN_q <= 1'b1;
    end else begin
      sync1_q <= load_n;
      syncN_q <= sync1_q;
    end
  end

  always_comb begin
    debCnt_d = '0;
    debN_d   = debN_q;
    if (syncN_q != debN_q) begin
      if (debCnt_q == DEB_LAST) begin
        debN_d = syncN_q;
      end else begin
        debCnt_d = debCnt_q + 1'b1;
      end
    end
  end

  // The press pulse comes from the delayed copy of the debounced level.
  // This sets the total latency from the first low sample to DEBOUNCE_CYCLES+2 cycles.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      debCnt_q  <= '0;
      debN_q    <= 1'b1;
      debPrev_q <= 1'b1;
      press_q   <= 1'b0;
    end else begin
      debCnt_q  <= debCnt_d;
      debN_q    <= debN_d;
      debPrev_q <= debN_q;
      press_q   <= debPrev_q & ~debN_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= S_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A:    if (press_q) state_d = S_B;
      S_B:    if (press_q) state_d = S_SUM;
      S_SUM:  if (settleCnt_q == SETTLE_LAST) state_d = S_SHOW;
      S_SHOW: if (press_q) state_d = S_B;
    endcase
  end

  // In S_SUM a press is dropped outright, so it cannot count as a later entry.
  always_comb begin
    opA_d       = opA_q;
    opB_d       = opB_q;
    cin_d       = cin_q;
    valid_d     = valid_q;
    result_d    = result_q;
    settleCnt_d = settleCnt_q;
    case (state_q)
      S_A: begin
        if (press_q) opA_d = sw_data;
      end
      S_B: begin
        if (press_q) begin
          opB_d       = sw_data;
          cin_d       = sw_cin;
          settleCnt_d = '0;
        end
      end
      S_SUM: begin
        settleCnt_d = settleCnt_q + 1'b1;
        if (settleCnt_q == SETTLE_LAST) begin
          result_d = {cout_in, sum_in};
          valid_d  = 1'b1;
        end
      end
      S_SHOW: begin
        if (press_q) begin
          valid_d = 1'b0;
          opA_d   = sw_data;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      opA_q       <= '0;
      opB_q       <= '0;
      cin_q       <= 1'b0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      settleCnt_q <= '0;
    end else begin
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      cin_q       <= cin_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      settleCnt_q <= settleCnt_d;
    end
  end

  assign op_a         = opA_q;
  assign op_b         = opB_q;
  assign cin          = cin_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign stage        = state_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer: directed and random operand entries on a board-adder model.
// A second instance with a long settle window covers presses that arrive during S_SUM.
module tb_adder_operand_sequencer;

  localparam int DEB     = 4;
  localparam int SETTLE  = 4;
  localparam int SETTLE2 = 24;

  logic       clk = 1'b0;
  logic       resetn, load_n, sw_cin, cin, cout_in, result_valid;
  logic [3:0] sw_data, sum_in, op_a, op_b;
  logic [4:0] result;
  logic [1:0] stage;

  logic       load2_n, sw2_cin, cin2, cout2, valid2;
  logic [3:0] sw2_data, sum2, opA2, opB2;
  logic [4:0] result2;
  logic [1:0] stage2;

  int         errors = 0;
  int         checks = 0;
  int         a, b, c;
  logic [4:0] lastResult;

  always #5 clk = ~clk;

  assign {cout_in, sum_in} = {1'b0, op_a} + {1'b0, op_b} + {4'b0, cin};
  assign {cout2, sum2}     = {1'b0, opA2} + {1'b0, opB2} + {4'b0, cin2};

  adder_operand_sequencer #(.DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SETTLE)) dut (
    .CLOCK_50(clk), .resetn(resetn), .sw_data(sw_data), .sw_cin(sw_cin),
    .load_n(load_n), .sum_in(sum_in), .cout_in(cout_in), .op_a(op_a),
    .op_b(op_b), .cin(cin), .result(result), .result_valid(result_valid),
    .stage(stage)
  );

  adder_operand_sequencer #(.DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SETTLE2)) dut2 (
    .CLOCK_50(clk), .resetn(resetn), .sw_data(sw2_data), .sw_cin(sw2_cin),
    .load_n(load2_n), .sum_in(sum2), .cout_in(cout2), .op_a(opA2),
    .op_b(opB2), .cin(cin2), .result(result2), .result_valid(valid2),
    .stage(stage2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_op_a"}, op_a, 0);
    checkOutput({tag, "_op_b"}, op_b, 0);
    checkOutput({tag, "_cin"}, cin, 0);
    checkOutput({tag, "_result"}, result, 0);
    checkOutput({tag, "_valid"}, result_valid, 0);
    checkOutput({tag, "_stage"}, stage, 0);
  endtask

  // Press and release the button with operand A on the switches.
  task automatic applyStimulus(input int av);
    sw_data = 4'(av);
    load_n  = 1'b0;
    repeat (DEB + 4) tick();
    load_n  = 1'b1;
    sw_data = 4'($urandom);
    repeat (DEB + 4) tick();
    checkOutput("enterA_op_a", op_a, av);
    checkOutput("enterA_stage", stage, 1);
    checkOutput("enterA_valid", result_valid, 0);
    checkOutput("enterA_result_held", result, lastResult);
  endtask

  // Enter B and carry-in, then check the settle timing and the latched sum.
  task automatic enterB(input int av, input int bv, input int cv);
    int expSum;
    expSum  = av + bv + cv;
    sw_data = 4'(bv);
    sw_cin  = 1'(cv);
    load_n  = 1'b0;
    repeat (DEB + 4) tick();
    checkOutput("enterB_op_b", op_b, bv);
    checkOutput("enterB_cin", cin, cv);
    checkOutput("enterB_stage", stage, 2);
    load_n = 1'b1;
    for (int k = 1; k <= SETTLE; k++) begin
      sw_data = 4'($urandom);
      sw_cin  = 1'($urandom);
      tick();
      if (k < SETTLE) begin
        checkOutput("settle_valid_low", result_valid, 0);
      end else begin
        checkOutput("latch_valid", result_valid, 1);
        checkOutput("latch_result", result, expSum);
        checkOutput("latch_stage", stage, 3);
      end
    end
    lastResult = 5'(expSum);
    repeat (DEB + 4) tick();
    checkOutput("show_result_held", result, expSum);
    checkOutput("show_op_a_held", op_a, av);
    checkOutput("show_op_b_held", op_b, bv);
  endtask

  initial begin
    resetn     = 1'b0;
    load_n     = 1'b1;
    sw_data    = 4'd0;
    sw_cin     = 1'b0;
    load2_n    = 1'b1;
    sw2_data   = 4'd0;
    sw2_cin    = 1'b0;
    lastResult = 5'd0;

    repeat (3) tick();
    checkReset("reset");
    resetn = 1'b1;
    repeat (100) tick();
    checkOutput("idle_stage", stage, 0);

    load_n = 1'b0;
    repeat (3) tick();
    load_n = 1'b1;
    repeat (12) tick();
    checkOutput("glitch_stage", stage, 0);

    sw_data = 4'd9;
    load_n  = 1'b0;
    repeat (DEB + 3) tick();
    checkOutput("press_early_stage", stage, 0);
    tick();
    checkOutput("press_latency_stage", stage, 1);
    checkOutput("press_op_a", op_a, 9);
    repeat (20 - (DEB + 4)) tick();
    checkOutput("hold_single_press", stage, 1);
    load_n  = 1'b1;
    sw_data = 4'd2;
    repeat (DEB + 4) tick();
    checkOutput("release_op_a", op_a, 9);
    enterB(9, 8, 1);

    applyStimulus(15);
    enterB(15, 15, 1);
    applyStimulus(0);
    enterB(0, 0, 0);
    applyStimulus(3);
    enterB(3, 12, 0);

    for (int i = 0; i < 4; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      c = int'($urandom_range(0, 1));
      applyStimulus(a);
      enterB(a, b, c);
    end

    // A press during the long settle window must be dropped without changing timing.
    sw2_data = 4'd5;
    load2_n  = 1'b0;
    repeat (DEB + 4) tick();
    load2_n  = 1'b1;
    repeat (DEB + 4) tick();
    checkOutput("ign_op_a", opA2, 5);
    sw2_data = 4'd6;
    sw2_cin  = 1'b0;
    load2_n  = 1'b0;
    repeat (DEB + 4) tick();
    checkOutput("ign_stage_sum", stage2, 2);
    load2_n = 1'b1;
    for (int t = 1; t <= SETTLE2; t++) begin
      sw2_data = 4'($urandom);
      sw2_cin  = 1'($urandom);
      load2_n  = (t >= 8 && t <= 19) ? 1'b0 : 1'b1;
      tick();
      if (t == SETTLE2 - 1) begin
        checkOutput("ign_op_b", opB2, 6);
        checkOutput("ign_cin", cin2, 0);
        checkOutput("ign_valid_low", valid2, 0);
        checkOutput("ign_stage_still_sum", stage2, 2);
      end else if (t == SETTLE2) begin
        checkOutput("ign_valid", valid2, 1);
        checkOutput("ign_result", result2, 11);
        checkOutput("ign_stage_show", stage2, 3);
      end
    end
    repeat (DEB + 4) tick();
    checkOutput("ign_no_queued_press", stage2, 3);

    applyStimulus(7);
    sw_data = 4'd4;
    load_n  = 1'b0;
    repeat (DEB + 4) tick();
    checkOutput("midsum_stage", stage, 2);
    tick();
    resetn = 1'b0;
    load_n = 1'b1;
    tick();
    checkReset("reset_in_sum");
    resetn = 1'b1;
    repeat (30) tick();
    checkOutput("after_sum_reset_stage", stage, 0);
    checkOutput("after_sum_reset_valid", result_valid, 0);

    load_n = 1'b0;
    repeat (DEB + 2) tick();
    resetn = 1'b0;
    tick();
    load_n = 1'b1;
    checkReset("reset_in_debounce");
    resetn = 1'b1;
    repeat (20) tick();
    checkOutput("no_stale_press_stage", stage, 0);
    checkOutput("no_stale_press_op_a", op_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
